// File: rtl/time_report_pkg.sv
// Shared constants and types for the time read-out (UART report) path.
// Contents: ASCII constants, frame lengths, 24-bit time field layout,
// FSM state encoding and a prefix-character helper.
package time_report_pkg;

  // ASCII characters used in the report frame
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_S     = 8'h53;

  localparam int unsigned FRAME_LEN_CRLF   = 14;
  localparam int unsigned FRAME_LEN_NOCRLF = 12;

  localparam int unsigned TIME_W  = 24;
  localparam int unsigned FIELD_W = 7;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned BYTE_W  = 8;

  // Bit positions of the packed time word
  localparam int unsigned MSEC_LSB = 0;
  localparam int unsigned MSEC_W   = 7;
  localparam int unsigned SEC_LSB  = 7;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_LSB  = 13;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_LSB = 19;
  localparam int unsigned HOUR_W   = 5;

  // Packed time word, MSB field first: hour[23:19] min[18:13] sec[12:7] msec[6:0]
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_DONE
  } state_t;

  // Frame prefix: 'W' for watch mode, 'S' for stopwatch mode
  function automatic logic [BYTE_W-1:0] prefix_char(input logic sel_mode);
    return sel_mode ? ASCII_W : ASCII_S;
  endfunction

endpackage

// File: rtl/time_report_tx_if.sv
// Byte handshake between the time reporter and the UART transmitter.
//   o_tx_data  : byte to transmit (reporter -> UART)
//   o_tx_start : one-cycle launch pulse (reporter -> UART)
//   i_tx_busy  : UART busy flag (UART -> reporter)
// master = reporter side, slave = UART side.
interface time_report_tx_if;
  import time_report_pkg::*;

  logic [BYTE_W-1:0] o_tx_data;
  logic              o_tx_start;
  logic              i_tx_busy;

  modport master (output o_tx_data, output o_tx_start, input i_tx_busy);
  modport slave  (input o_tx_data, input o_tx_start, output i_tx_busy);
endinterface

// File: rtl/time_report_tx_bin2ascii_2digit.sv
// Combinational conversion of a 0..127 field value to two ASCII decimal
// digits, saturating at "99".
//   value  : 7-bit binary field value
//   tens_c : ASCII tens digit
//   ones_c : ASCII ones digit
module bin2ascii_2digit
  import time_report_pkg::*;
(
  input  logic [FIELD_W-1:0] value,
  output logic [BYTE_W-1:0]  tens_c,
  output logic [BYTE_W-1:0]  ones_c
);

  logic [FIELD_W-1:0] sat_c;

  // Clamp to 99, then split into decimal digits
  always_comb begin
    sat_c  = (value > 7'd99) ? 7'd99 : value;
    tens_c = ASCII_0 + 8'(sat_c / 7'd10);
    ones_c = ASCII_0 + 8'(sat_c % 7'd10);
  end

endmodule

// File: rtl/time_report_tx.sv
// Serialises a snapshot of the packed 24-bit time into an ASCII frame
// "<W|S>HH:MM:SS.CC[CR LF]" one byte at a time over the UART TX handshake.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   i_send      : report request, accepted only when idle
//   i_sel_mode  : 1 = watch ('W'), 0 = stopwatch ('S')
//   i_time_data : packed time {hour[4:0], min[5:0], sec[5:0], msec[6:0]}
//   tx          : UART byte handshake (o_tx_data, o_tx_start, i_tx_busy)
//   o_busy      : frame in progress
//   o_done      : one-cycle pulse after the last byte completes
module time_report_tx
  import time_report_pkg::*;
#(
  parameter bit USE_CRLF = 1'b1
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_send,
  input  logic                i_sel_mode,
  input  logic [TIME_W-1:0]   i_time_data,
  time_report_tx_if.master    tx,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned FRAME_LEN = USE_CRLF ? FRAME_LEN_CRLF : FRAME_LEN_NOCRLF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  time_t             snap_time;
  logic              snap_mode;

  logic [BYTE_W-1:0] hour_t_c, hour_o_c;
  logic [BYTE_W-1:0] min_t_c,  min_o_c;
  logic [BYTE_W-1:0] sec_t_c,  sec_o_c;
  logic [BYTE_W-1:0] msec_t_c, msec_o_c;
  logic [BYTE_W-1:0] frame_byte_c;

  // Digit converters work from the snapshot only
  bin2ascii_2digit u_hour (
    .value  (FIELD_W'(snap_time.hour)),
    .tens_c (hour_t_c),
    .ones_c (hour_o_c)
  );

  bin2ascii_2digit u_min (
    .value  (FIELD_W'(snap_time.min)),
    .tens_c (min_t_c),
    .ones_c (min_o_c)
  );

  bin2ascii_2digit u_sec (
    .value  (FIELD_W'(snap_time.sec)),
    .tens_c (sec_t_c),
    .ones_c (sec_o_c)
  );

  bin2ascii_2digit u_msec (
    .value  (snap_time.msec),
    .tens_c (msec_t_c),
    .ones_c (msec_o_c)
  );

  // Frame byte selected by the current index
  always_comb begin
    frame_byte_c = 8'h00;
    case (idx)
      4'd0:    frame_byte_c = prefix_char(snap_mode);
      4'd1:    frame_byte_c = hour_t_c;
      4'd2:    frame_byte_c = hour_o_c;
      4'd3:    frame_byte_c = ASCII_COLON;
      4'd4:    frame_byte_c = min_t_c;
      4'd5:    frame_byte_c = min_o_c;
      4'd6:    frame_byte_c = ASCII_COLON;
      4'd7:    frame_byte_c = sec_t_c;
      4'd8:    frame_byte_c = sec_o_c;
      4'd9:    frame_byte_c = ASCII_DOT;
      4'd10:   frame_byte_c = msec_t_c;
      4'd11:   frame_byte_c = msec_o_c;
      4'd12:   frame_byte_c = ASCII_CR;
      4'd13:   frame_byte_c = ASCII_LF;
      default: frame_byte_c = 8'h00;
    endcase
  end

  // Frame sequencer with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      snap_time     <= '0;
      snap_mode     <= 1'b0;
      tx.o_tx_data  <= 8'h00;
      tx.o_tx_start <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      tx.o_tx_start <= 1'b0;
      o_done        <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_send) begin
            snap_time <= time_t'(i_time_data);
            snap_mode <= i_sel_mode;
            idx       <= '0;
            o_busy    <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx.i_tx_busy) begin
            tx.o_tx_data  <= frame_byte_c;
            tx.o_tx_start <= 1'b1;
            state         <= ST_WAIT_ACK;
          end
        end
        // Wait for the UART to pick up the byte
        ST_WAIT_ACK: begin
          if (tx.i_tx_busy) begin
            state <= ST_WAIT_DONE;
          end
        end
        // Wait for the byte to finish, then advance or finish the frame
        ST_WAIT_DONE: begin
          if (!tx.i_tx_busy) begin
            if (idx == LAST_IDX) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_report_tx.sv
// Self-checking bench for time_report_tx: one instance with CR LF, one without,
// each driven by a simple UART model that holds busy for 10 cycles per byte.
module tb_time_report_tx;
  import time_report_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        send_a, mode_a, send_b, mode_b;
  logic [23:0] time_a, time_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic        model_busy_a = 1'b0;
  logic        model_busy_b = 1'b0;
  logic        hold_b = 1'b0;

  time_report_tx_if tx_a ();
  time_report_tx_if tx_b ();

  assign tx_a.i_tx_busy = model_busy_a;
  assign tx_b.i_tx_busy = model_busy_b | hold_b;

  time_report_tx #(.USE_CRLF(1'b1)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .i_send      (send_a),
    .i_sel_mode  (mode_a),
    .i_time_data (time_a),
    .tx          (tx_a.master),
    .o_busy      (busy_a),
    .o_done      (done_a)
  );

  time_report_tx #(.USE_CRLF(1'b0)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .i_send      (send_b),
    .i_sel_mode  (mode_b),
    .i_time_data (time_b),
    .tx          (tx_b.master),
    .o_busy      (busy_b),
    .o_done      (done_b)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  // UART models: busy rises the cycle after a start and lasts 10 cycles
  initial forever begin
    @(posedge clk); #1;
    if (tx_a.o_tx_start) begin
      model_busy_a = 1'b1;
      repeat (10) @(posedge clk);
      #1 model_busy_a = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (tx_b.o_tx_start) begin
      model_busy_b = 1'b1;
      repeat (10) @(posedge clk);
      #1 model_busy_b = 1'b0;
    end
  end

  // Monitors: capture every launched byte and count done pulses
  initial forever begin
    @(posedge clk); #1;
    if (tx_a.o_tx_start) cap_a.push_back(tx_a.o_tx_data);
    if (tx_b.o_tx_start) cap_b.push_back(tx_b.o_tx_data);
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input bit b, input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (b ? done_b : done_a) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: o_done not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_bytes(input int n, input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (cap_a.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: only %0d bytes after %0d cycles, wanted %0d", name, cap_a.size(), limit, n);
    end
  endtask

  task automatic check_frame(input bit b, input logic [95:0] e, input bit crlf, input string name);
    logic [7:0] q[$];
    int n;
    logic [7:0] exp_byte;
    logic [31:0] act;
    q = b ? cap_b : cap_a;
    n = crlf ? 14 : 12;
    chk({name, " byte count"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < 12) exp_byte = e[8*(11-i) +: 8];
      else if (i == 12) exp_byte = 8'h0D;
      else exp_byte = 8'h0A;
      act = (i < q.size()) ? 32'(q[i]) : 32'h100;
      chk($sformatf("%s byte %0d", name, i), act, 32'(exp_byte));
    end
    chk({name, " done count"}, 32'(b ? done_cnt_b : done_cnt_a), 32'd1);
  endtask

  task automatic clear_caps();
    cap_a.delete();
    cap_b.delete();
    done_cnt_a = 0;
    done_cnt_b = 0;
  endtask

  task automatic run_frame(input bit b, input logic sel, input logic [23:0] t,
                           input logic [95:0] e, input string name);
    clear_caps();
    @(negedge clk);
    if (b) begin mode_b = sel; time_b = t; send_b = 1'b1; end
    else   begin mode_a = sel; time_a = t; send_a = 1'b1; end
    @(negedge clk);
    send_a = 1'b0;
    send_b = 1'b0;
    wait_done(b, 600, name);
    repeat (3) @(posedge clk);
    #1;
    check_frame(b, e, !b, name);
  endtask

  typedef struct {
    logic        sel;
    logic [23:0] t;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs[5];
  bit   dropped;

  initial begin
    vecs[0] = '{1'b1, {5'd12, 6'd0,  6'd0,  7'd0},   "W12:00:00.00"};
    vecs[1] = '{1'b0, {5'd23, 6'd59, 6'd59, 7'd99},  "S23:59:59.99"};
    vecs[2] = '{1'b1, {5'd0,  6'd0,  6'd0,  7'd120}, "W00:00:00.99"};
    vecs[3] = '{1'b0, {5'd31, 6'd7,  6'd45, 7'd5},   "S31:07:45.05"};
    vecs[4] = '{1'b1, {5'd9,  6'd30, 6'd0,  7'd100}, "W09:30:00.99"};

    reset = 1'b0;
    send_a = 1'b0; mode_a = 1'b0; time_a = '0;
    send_b = 1'b0; mode_b = 1'b0; time_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx_data a",  32'(tx_a.o_tx_data),  32'h00);
    chk("reset tx_start a", 32'(tx_a.o_tx_start), 32'h0);
    chk("reset busy a",     32'(busy_a),          32'h0);
    chk("reset done a",     32'(done_a),          32'h0);
    chk("reset tx_data b",  32'(tx_b.o_tx_data),  32'h00);
    chk("reset busy b",     32'(busy_b),          32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // First-byte latency with the UART idle, then the full watch frame
    clear_caps();
    @(negedge clk);
    mode_a = vecs[0].sel; time_a = vecs[0].t; send_a = 1'b1;
    @(posedge clk); #1;
    chk("latency start after accept", 32'(tx_a.o_tx_start), 32'h0);
    chk("latency busy after accept",  32'(busy_a),          32'h1);
    send_a = 1'b0;
    @(posedge clk); #1;
    chk("latency first start", 32'(tx_a.o_tx_start), 32'h1);
    chk("latency first byte",  32'(tx_a.o_tx_data),  32'h57);
    wait_done(1'b0, 600, "watch frame");
    repeat (3) @(posedge clk);
    #1;
    check_frame(1'b0, vecs[0].exp, 1'b1, "watch frame");
    chk("idle busy after frame", 32'(busy_a), 32'h0);

    // Table-driven frames
    for (int v = 1; v < 5; v++) begin
      run_frame(1'b0, vecs[v].sel, vecs[v].t, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Mid-frame input changes and a second request are ignored
    clear_caps();
    @(negedge clk);
    mode_a = 1'b1; time_a = {5'd12, 6'd34, 6'd56, 7'd78}; send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
    wait_bytes(5, 300, "midframe reach byte 4");
    @(negedge clk);
    time_a = '1; mode_a = 1'b0; send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (done_a) break;
      if (!busy_a) dropped = 1'b1;
    end
    chk("midframe busy held", 32'(dropped), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_frame(1'b0, "W12:34:56.78", 1'b1, "midframe");
    repeat (40) @(posedge clk);
    #1;
    chk("midframe no second frame", 32'(cap_a.size()), 32'd14);
    chk("midframe idle after", 32'(busy_a), 32'h0);

    // Reset during byte 6 aborts the frame
    clear_caps();
    @(negedge clk);
    mode_a = 1'b1; time_a = {5'd1, 6'd2, 6'd3, 7'd4}; send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
    wait_bytes(7, 300, "reset reach byte 6");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset tx_start", 32'(tx_a.o_tx_start), 32'h0);
    chk("midreset busy",     32'(busy_a),          32'h0);
    chk("midreset done",     32'(done_a),          32'h0);
    chk("midreset tx_data",  32'(tx_a.o_tx_data),  32'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("after reset no done", 32'(done_cnt_a), 32'd0);
    run_frame(1'b0, 1'b0, {5'd7, 6'd8, 6'd9, 7'd10}, "S07:08:09.10", "after reset");

    // No CR LF, UART busy before the request
    clear_caps();
    hold_b = 1'b1;
    @(negedge clk);
    mode_b = 1'b1; time_b = {5'd0, 6'd1, 6'd2, 7'd3}; send_b = 1'b1;
    @(negedge clk);
    send_b = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("nocrlf no start while busy", 32'(cap_b.size()), 32'd0);
    chk("nocrlf busy while blocked",  32'(busy_b),       32'h1);
    @(negedge clk);
    hold_b = 1'b0;
    wait_done(1'b1, 600, "nocrlf");
    chk("nocrlf bytes at done", 32'(cap_b.size()), 32'd12);
    repeat (3) @(posedge clk);
    #1;
    check_frame(1'b1, "W00:01:02.03", 1'b0, "nocrlf");
    run_frame(1'b1, vecs[1].sel, vecs[1].t, vecs[1].exp, "nocrlf vec1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
